// File: rtl/io_seq_monitor_if.sv
// Bundle of the monitor's control inputs, pad bus and verdict/progress outputs.
// The master drives control and io_in; the slave (the monitor) drives the results.
interface io_seq_monitor_if;
  logic       enable;
  logic       clear;
  logic [7:0] io_in;
  logic [7:0] accepted_value;
  logic       accepted_strobe;
  logic [3:0] step;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [1:0] fail_code;

  modport master (
    output enable, clear, io_in,
    input  accepted_value, accepted_strobe, step, busy, pass, fail, fail_code
  );

  modport slave (
    input  enable, clear, io_in,
    output accepted_value, accepted_strobe, step, busy, pass, fail, fail_code
  );
endinterface

// File: rtl/io_seq_monitor.sv
// Glitch-filtered monitor of the mprj_io[7:0] firmware count pattern 01..0A, FF, 00
// with a sticky pass/fail verdict, progress step and timeout supervision.
module io_seq_monitor #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 25000,
  parameter bit          STRICT         = 1'b0
) (
  input logic             clock,
  input logic             resetb,
  io_seq_monitor_if.slave mon
);

  localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    STEP_LAST = 4'd11;

  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_PASS, ST_FAIL} state_e;
  typedef enum logic [1:0] {FC_NONE = 2'd0, FC_MISMATCH = 2'd1, FC_TIMEOUT = 2'd2} fail_code_e;

  function automatic logic [7:0] expected_at(input logic [3:0] k);
    if (k <= 4'd9)       return {4'h0, k} + 8'd1;
    else if (k == 4'd10) return 8'hFF;
    else                 return 8'h00;
  endfunction

  logic [7:0]    sync1_q, sync_q, hold_q;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [7:0]    acc_q, acc_d;
  logic          strobe_q, strobe_d;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    stab_cnt_d = stab_cnt_q;
    acc_d      = acc_q;
    strobe_d   = 1'b0;
    if (sync_q != hold_q)
      stab_cnt_d = '0;
    else if (stab_cnt_q != STAB_MAX)
      stab_cnt_d = stab_cnt_q + 1'b1;
    // A candidate that only repeats the current value is not an event.
    if (sync_q == hold_q && stab_cnt_q == STAB_MAX && sync_q != acc_q) begin
      acc_d    = sync_q;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      hold_q     <= '0;
      stab_cnt_q <= '0;
      acc_q      <= '0;
      strobe_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, giving a true shift chain.
      sync1_q    <= mon.io_in;
      sync_q     <= sync1_q;
      hold_q     <= sync_q;
      stab_cnt_q <= stab_cnt_d;
      acc_q      <= acc_d;
      strobe_q   <= strobe_d;
    end
  end

  state_e     state_q;
  fail_code_e fail_code_q;
  logic [3:0] step_q;
  logic [TW-1:0] timer_q;
  logic busy_q, pass_q, fail_q;
  logic seq_hit, seq_miss;

  assign seq_hit  = strobe_q && (acc_q == expected_at(step_q));
  assign seq_miss = strobe_q && !seq_hit && (step_q != 4'd0);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      fail_code_q <= FC_NONE;
      step_q      <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else if (mon.clear) begin
      state_q     <= ST_IDLE;
      fail_code_q <= FC_NONE;
      step_q      <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else if (!mon.enable) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q     <= ST_TRACK;
          fail_code_q <= FC_NONE;
          step_q      <= '0;
          timer_q     <= '0;
          busy_q      <= 1'b1;
          pass_q      <= 1'b0;
          fail_q      <= 1'b0;
        end
        ST_TRACK: begin
          if (seq_hit) step_q <= step_q + 4'd1;
          // A final match outranks a timeout landing in the same cycle.
          if (seq_hit && step_q == STEP_LAST) begin
            state_q <= ST_PASS;
            busy_q  <= 1'b0;
            pass_q  <= 1'b1;
          end else if (seq_miss && STRICT) begin
            state_q     <= ST_FAIL;
            fail_code_q <= FC_MISMATCH;
            busy_q      <= 1'b0;
            fail_q      <= 1'b1;
          end else if (timer_q == TIMER_MAX) begin
            state_q     <= ST_FAIL;
            fail_code_q <= FC_TIMEOUT;
            busy_q      <= 1'b0;
            fail_q      <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mon.accepted_value  = acc_q;
  assign mon.accepted_strobe = strobe_q;
  assign mon.step            = step_q;
  assign mon.busy            = busy_q;
  assign mon.pass            = pass_q;
  assign mon.fail            = fail_q;
  assign mon.fail_code       = fail_code_q;

endmodule

// File: tb/tb_io_seq_monitor.sv
// Bench for io_seq_monitor: a lax (STRICT=0) and a strict (STRICT=1) instance share
// stimulus and are compared every cycle against a window-based behavioural model.
module tb_io_seq_monitor;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 1000;

  logic clock = 1'b0;
  logic resetb;
  always #5 clock = ~clock;

  io_seq_monitor_if if_lax ();
  io_seq_monitor_if if_strict ();

  io_seq_monitor #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT), .STRICT(1'b0)) u_lax (
    .clock(clock), .resetb(resetb), .mon(if_lax));
  io_seq_monitor #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT), .STRICT(1'b1)) u_strict (
    .clock(clock), .resetb(resetb), .mon(if_strict));

  typedef enum {M_IDLE, M_TRACK, M_PASS, M_FAIL} mode_e;
  typedef struct {
    mode_e mode;
    int    step;
    bit    pass;
    bit    fail;
    int    code;
    int    track_edges;
  } seq_t;

  seq_t       m [2];
  logic [7:0] io_hist[$];
  logic [7:0] m_acc;
  bit         m_strobe;
  logic [7:0] cur_io;
  bit         cur_en, cur_clr;
  int checks   = 0;
  int failures = 0;

  function automatic int expected_value(input int k);
    if (k < 10)  return k + 1;
    if (k == 10) return 255;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    io_hist.delete();
    for (int i = 0; i < STABLE + 3; i++) io_hist.push_back(8'h00);
    m_acc    = 8'h00;
    m_strobe = 1'b0;
    for (int i = 0; i < 2; i++)
      m[i] = '{mode: M_IDLE, step: 0, pass: 1'b0, fail: 1'b0, code: 0, track_edges: 0};
  endtask

  task automatic seq_update(input int i, input bit st, input logic [7:0] av);
    if (cur_clr) begin
      m[i] = '{mode: M_IDLE, step: 0, pass: 1'b0, fail: 1'b0, code: 0, track_edges: 0};
    end else if (!cur_en) begin
      m[i].mode = M_IDLE;
    end else if (m[i].mode == M_IDLE) begin
      m[i] = '{mode: M_TRACK, step: 0, pass: 1'b0, fail: 1'b0, code: 0, track_edges: 0};
    end else if (m[i].mode == M_TRACK) begin
      m[i].track_edges++;
      if (st && int'(av) == expected_value(m[i].step)) begin
        m[i].step++;
        if (m[i].step == 12) begin
          m[i].mode = M_PASS;
          m[i].pass = 1'b1;
        end
      end else if (st && m[i].step > 0 && i == 1) begin
        m[i].mode = M_FAIL;
        m[i].fail = 1'b1;
        m[i].code = 1;
      end
      if (m[i].mode == M_TRACK && m[i].track_edges == TIMEOUT) begin
        m[i].mode = M_FAIL;
        m[i].fail = 1'b1;
        m[i].code = 2;
      end
    end
  endtask

  // A value is accepted once S+1 consecutive synchronized samples agree and differ
  // from the current accepted value; synchronized samples trail io_in by two edges.
  task automatic model_edge();
    bit         pre_strobe = m_strobe;
    logic [7:0] pre_acc    = m_acc;
    bit         same       = 1'b1;
    int         n;
    io_hist.push_back(cur_io);
    n = io_hist.size();
    for (int j = 0; j <= STABLE; j++)
      if (io_hist[n-3-j] != io_hist[n-3]) same = 1'b0;
    m_strobe = 1'b0;
    if (same && io_hist[n-3] != m_acc) begin
      m_acc    = io_hist[n-3];
      m_strobe = 1'b1;
    end
    while (io_hist.size() > STABLE + 3) void'(io_hist.pop_front());
    for (int i = 0; i < 2; i++) seq_update(i, pre_strobe, pre_acc);
  endtask

  task automatic compare_one(input string name, input int i, input logic [7:0] av,
                             input logic st, input logic [3:0] sp, input logic bz,
                             input logic ps, input logic fl, input logic [1:0] fc);
    chk($sformatf("%s.accepted_value", name), 32'(av), 32'(m_acc));
    chk($sformatf("%s.accepted_strobe", name), 32'(st), 32'(m_strobe));
    chk($sformatf("%s.step", name), 32'(sp), 32'(m[i].step));
    chk($sformatf("%s.busy", name), 32'(bz), 32'(m[i].mode == M_TRACK));
    chk($sformatf("%s.pass", name), 32'(ps), 32'(m[i].pass));
    chk($sformatf("%s.fail", name), 32'(fl), 32'(m[i].fail));
    chk($sformatf("%s.fail_code", name), 32'(fc), 32'(m[i].code));
  endtask

  task automatic compare_all();
    compare_one("lax", 0, if_lax.accepted_value, if_lax.accepted_strobe, if_lax.step,
                if_lax.busy, if_lax.pass, if_lax.fail, if_lax.fail_code);
    compare_one("strict", 1, if_strict.accepted_value, if_strict.accepted_strobe, if_strict.step,
                if_strict.busy, if_strict.pass, if_strict.fail, if_strict.fail_code);
  endtask

  task automatic drive(input logic [7:0] io, input bit en, input bit clr);
    cur_io  = io;
    cur_en  = en;
    cur_clr = clr;
    if_lax.io_in     = io;
    if_lax.enable    = en;
    if_lax.clear     = clr;
    if_strict.io_in  = io;
    if_strict.enable = en;
    if_strict.clear  = clr;
  endtask

  task automatic cycle(input logic [7:0] io, input bit en, input bit clr);
    drive(io, en, clr);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic hold(input logic [7:0] io, input int n);
    for (int c = 0; c < n; c++) cycle(io, 1'b1, 1'b0);
  endtask

  task automatic run_seq(input int first, input int last);
    for (int k = first; k <= last; k++) hold(8'(expected_value(k)), 20);
  endtask

  initial begin
    int seen55;
    resetb = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    model_reset();
    #23;
    compare_all();
    @(negedge clock);
    resetb = 1'b1;

    // Nominal pattern, then enable-low keeps the verdict.
    cycle(8'h00, 1'b1, 1'b0);
    run_seq(0, 11);
    chk("nominal.pass", 32'(if_lax.pass), 32'd1);
    chk("nominal.step", 32'(if_strict.step), 32'd12);
    chk("nominal.busy", 32'(if_lax.busy), 32'd0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("disable.pass_kept", 32'(if_lax.pass), 32'd1);

    // Glitch of 55 for two cycles between 03 and 04.
    cycle(8'h00, 1'b1, 1'b1);
    run_seq(0, 2);
    hold(8'h55, 2);
    seen55 = 0;
    for (int c = 0; c < 20; c++) begin
      hold(8'h04, 1);
      if (if_lax.accepted_value == 8'h55) seen55++;
    end
    chk("glitch.no55", 32'(seen55), 32'd0);
    chk("glitch.step", 32'(if_lax.step), 32'd4);
    run_seq(4, 11);
    chk("glitch.pass", 32'(if_strict.pass), 32'd1);

    // Out-of-sequence 07 after 01,02.
    cycle(8'h00, 1'b1, 1'b1);
    run_seq(0, 1);
    hold(8'h07, 20);
    chk("strict.fail", 32'(if_strict.fail), 32'd1);
    chk("strict.code", 32'(if_strict.fail_code), 32'd1);
    chk("strict.step", 32'(if_strict.step), 32'd2);
    chk("lax.ignored", 32'(if_lax.fail), 32'd0);
    run_seq(2, 11);
    chk("lax.pass", 32'(if_lax.pass), 32'd1);
    chk("strict.held", 32'(if_strict.fail_code), 32'd1);

    // Timeout: fail lands exactly TIMEOUT edges after the entry edge.
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h01, 1'b1, 1'b0);
    hold(8'h01, TIMEOUT - 1);
    chk("timeout.early", 32'(if_lax.fail), 32'd0);
    hold(8'h01, 1);
    chk("timeout.fail", 32'(if_lax.fail), 32'd1);
    chk("timeout.code", 32'(if_strict.fail_code), 32'd2);
    chk("timeout.step", 32'(if_lax.step), 32'd1);

    // Mismatches while unarmed are ignored even when strict.
    cycle(8'h01, 1'b1, 1'b1);
    hold(8'h00, 20);
    hold(8'h33, 20);
    hold(8'h09, 20);
    chk("unarmed.step", 32'(if_strict.step), 32'd0);
    chk("unarmed.fail", 32'(if_strict.fail), 32'd0);
    run_seq(0, 11);
    chk("unarmed.pass", 32'(if_strict.pass), 32'd1);

    // clear at step 5, re-entry, then asynchronous reset at step 7.
    cycle(8'h00, 1'b1, 1'b1);
    run_seq(0, 4);
    chk("clear.before", 32'(if_lax.step), 32'd5);
    cycle(8'h05, 1'b1, 1'b1);
    chk("clear.step", 32'(if_lax.step), 32'd0);
    chk("clear.busy", 32'(if_lax.busy), 32'd0);
    cycle(8'h05, 1'b1, 1'b0);
    chk("clear.reenter", 32'(if_lax.busy), 32'd1);
    run_seq(0, 6);
    chk("reset.before", 32'(if_strict.step), 32'd7);
    #2 resetb = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("reset.acc", 32'(if_lax.accepted_value), 32'd0);
    @(negedge clock);
    resetb = 1'b1;

    // Randomized segments with occasional glitches, disables and clears.
    for (int s = 0; s < 120; s++) begin
      int         kind = int'($urandom_range(0, 9));
      int         len  = int'($urandom_range(1, 24));
      logic [7:0] v;
      if (kind < 5)      v = 8'(expected_value(m[0].step < 12 ? m[0].step : 0));
      else if (kind < 8) v = 8'($urandom);
      else               v = cur_io;
      if ($urandom_range(0, 19) == 0)      cycle(v, 1'b0, 1'b0);
      else if ($urandom_range(0, 29) == 0) cycle(v, 1'b1, 1'b1);
      hold(v, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_seq_monitor.md
Name: io_seq_monitor

Overview:
- Synthesizable checker that sits downstream of the management-core GPIO outputs on mprj_io[7:0].
- Filters glitches on the 8-bit pad bus and verifies the firmware count pattern 01..0A, FF, 00.
- Reports a sticky pass/fail verdict with progress visibility. It is usable inside the user project for on-silicon self-test, and in the DV bench as a monitor.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples needed to accept a value (min 1).
- TIMEOUT_CYCLES, 25000: clock cycles allowed in TRACK before a timeout failure.
- STRICT, 0: 1 = any accepted out-of-sequence value after arming fails; 0 = such values are ignored.

Ports:
- clock  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- enable  input  1  level; high starts/keeps monitoring, low aborts to IDLE.
- clear  input  1  synchronous pulse; clears verdict and returns to IDLE.
- io_in  input  8  observed pad bus, asynchronous to clock.
- accepted_value  output  8  last filtered value.
- accepted_strobe  output  1  one-cycle pulse when accepted_value changes.
- step  output  4  index of next expected value (0..12).
- busy  output  1  high in TRACK.
- pass  output  1  sticky pass.
- fail  output  1  sticky fail.
- fail_code  output  2  0 none, 1 mismatch, 2 timeout.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, resetb). All flops reset on resetb low.
- Reset values: all outputs 0; accepted_value=8'h00; state IDLE.
- Input path: io_in goes through a 2-flop synchronizer to s, then a hold register h<=s.
  - stab_cnt resets to 0 when s!=h; otherwise it increments, saturating at STABLE_CYCLES-1.
  - A candidate is accepted in the cycle stab_cnt==STABLE_CYCLES-1 and s==h.
  - If the candidate differs from accepted_value: accepted_value<=s and accepted_strobe pulses the next cycle. Otherwise nothing happens.
  - Latency from a stable io_in change to strobe = 2 sync + STABLE_CYCLES + 1 cycles.
- Filtering runs in all states.
- Expected table by step:
  - k=0..9: k+1.
  - k=10: 8'hFF.
  - k=11: 8'h00.
  - step==12 means complete.
- States:
  - IDLE: busy=0. enable=1 and clear=0 -> TRACK; on entry step=0, timer=0, pass/fail/fail_code cleared.
  - TRACK: busy=1. Timer increments every cycle. On accepted_strobe, compare accepted_value to expected[step]:
    - match: step+1; if step was 11 -> PASS (pass=1).
    - mismatch with step==0 (unarmed): ignored.
    - mismatch with step>0: if STRICT=1 -> FAIL (code 1); else ignored.
    - timer reaching TIMEOUT_CYCLES-1 -> FAIL (code 2).
  - PASS / FAIL: verdict, step and accepted_value hold; busy=0.
- Exit from any state: enable=0 -> IDLE, verdict retained. clear=1 -> IDLE with verdict, fail_code and step cleared.
- Priorities:
  - clear > enable low > final match > mismatch > timeout.
  - A final match and a timeout in the same cycle resolve to PASS.
- pass and fail are never both 1.
- A value that repeats the previous accepted value never generates a strobe, so holding a value is not an event.
- Glitches shorter than STABLE_CYCLES synchronized cycles never reach accepted_value.
- Reset mid-TRACK: immediate return to reset values. No partial verdict survives.
- Timer width: clog2(TIMEOUT_CYCLES+1), no wrap; it stops counting outside TRACK.

Test Plan:
- Nominal: enable=1; drive 01..0A, FF, 00, each held 20 cycles -> 12 strobes, step 0->12, pass=1, fail=0, fail_code=0, busy=0.
- Glitch filter (STABLE_CYCLES=4): during step 3, pulse io_in=8'h55 for 2 cycles between 03 and 04 -> no strobe for 55, step advances to 4, final pass=1.
- Strict mismatch (STRICT=1): after 01,02 drive 07 for 20 cycles -> fail=1, fail_code=1, step=2. With STRICT=0 the same stimulus -> ignored, and continuing the sequence gives pass=1.
- Timeout (TIMEOUT_CYCLES=1000): enable, drive 01 then hold -> fail=1, fail_code=2 exactly 1000 cycles after entering TRACK, step=1.
- Unarmed ignore: drive 00, 33, 09 before 01 -> step stays 0, no fail even with STRICT=1; then the full sequence gives pass=1.
- Control/reset:
  - clear mid-TRACK at step 5 -> IDLE, step=0, verdict 0, re-enters TRACK next cycle if enable=1.
  - resetb low at step 7 -> all outputs 0 asynchronously, accepted_value=00.
